// File: rtl/spi_reg_pkg.sv
// Shared constants, FSM state type and raybox-zero register command codes
// for the SPI register-port transmitter.
package spi_reg_pkg;

  localparam int unsigned CMD_W       = 4;
  localparam int unsigned PAYLOAD_MAX = 24;
  localparam int unsigned LEN_W       = 5;
  localparam int unsigned DIV_W       = 8;
  localparam int unsigned FRAME_MAX   = CMD_W + PAYLOAD_MAX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_e;

  // raybox-zero register port command codes
  localparam logic [CMD_W-1:0] REG_SKY     = 4'd0;
  localparam logic [CMD_W-1:0] REG_FLOOR   = 4'd1;
  localparam logic [CMD_W-1:0] REG_LEAK    = 4'd2;
  localparam logic [CMD_W-1:0] REG_OTHER   = 4'd3;
  localparam logic [CMD_W-1:0] REG_VSHIFT  = 4'd4;
  localparam logic [CMD_W-1:0] REG_VINF    = 4'd5;
  localparam logic [CMD_W-1:0] REG_MAPD    = 4'd6;
  localparam logic [CMD_W-1:0] REG_TEXADD0 = 4'd7;
  localparam logic [CMD_W-1:0] REG_TEXADD1 = 4'd8;
  localparam logic [CMD_W-1:0] REG_TEXADD2 = 4'd9;
  localparam logic [CMD_W-1:0] REG_TEXADD3 = 4'd10;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(PAYLOAD_MAX)) ? LEN_W'(PAYLOAD_MAX) : len;
  endfunction

endpackage

// File: rtl/spi_reg_tx_tick.sv
// Load/expire down-counter that times each FSM state of spi_reg_tx.
// expire_o is high while the count has reached zero.
module spi_tick_gen
  import spi_reg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_reg_tx.sv
// SPI mode-0 frame transmitter for the raybox-zero register port:
// sends a 4-bit command code followed by 0..24 payload bits, MSB first.
module spi_reg_tx
  import spi_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CMD_W-1:0]       cmd_addr,
  input  logic [PAYLOAD_MAX-1:0] cmd_data,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  output logic                   spi_csb,
  output logic                   busy,
  output logic                   done
);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LOAD = DIV_W'(CS_GAP - 1);

  state_e               state_q;
  logic [FRAME_MAX-1:0] shift_q;
  logic [LEN_W-1:0]     bit_q;
  logic                 cmd_ready_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic                 csb_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept;
  logic [LEN_W-1:0]     len_clamped;
  logic [FRAME_MAX-1:0] frame_d;
  logic                 tick_load;
  logic [DIV_W-1:0]     tick_val;
  logic                 tick_expire;

  assign accept      = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
  assign len_clamped = clamp_len(cmd_len);
  // Payload is left-justified under the address so every frame leaves from the top bit.
  assign frame_d     = {cmd_addr, cmd_data << (LEN_W'(PAYLOAD_MAX) - len_clamped)};

  always_comb begin
    tick_load = 1'b0;
    tick_val  = DIV_LOAD;
    case (state_q)
      ST_IDLE:  tick_load = accept;
      ST_SETUP,
      ST_HIGH,
      ST_LOW:   tick_load = tick_expire;
      ST_HOLD: begin
        tick_load = tick_expire;
        tick_val  = GAP_LOAD;
      end
      ST_GAP: begin
        tick_load = tick_expire;
        tick_val  = '0;
      end
      default: tick_load = 1'b0;
    endcase
  end

  spi_tick_gen u_tick (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .expire_o   (tick_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      cmd_ready_q <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csb_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            state_q     <= ST_SETUP;
            shift_q     <= frame_d;
            bit_q       <= len_clamped + LEN_W'(CMD_W - 1);
            cmd_ready_q <= 1'b0;
            csb_q       <= 1'b0;
            mosi_q      <= frame_d[FRAME_MAX-1];
            busy_q      <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick_expire) begin
            state_q <= ST_HIGH;
            sclk_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (tick_expire) begin
            sclk_q <= 1'b0;
            if (bit_q != '0) begin
              state_q <= ST_LOW;
              shift_q <= {shift_q[FRAME_MAX-2:0], 1'b0};
              mosi_q  <= shift_q[FRAME_MAX-2];
              bit_q   <= bit_q - 1'b1;
            end else begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_LOW: begin
          if (tick_expire) begin
            state_q <= ST_HIGH;
            sclk_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick_expire) begin
            state_q <= ST_GAP;
            csb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (tick_expire) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_csb   = csb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_reg_tx.sv
// Self-checking bench for spi_reg_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each with a receiver that decodes frames and checks them against a scoreboard.
module tb_spi_reg_tx;
  import spi_reg_pkg::*;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;
  localparam int GAP  = 2;

  typedef struct {
    int          n;
    logic [3:0]  addr;
    logic [23:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [23:0] data;
    logic [4:0]  len;
    int          n;
    logic [23:0] pay;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  cmd_valid;
  logic [3:0]  cmd_addr [2];
  logic [23:0] cmd_data [2];
  logic [4:0]  cmd_len  [2];
  logic a_ready, a_sclk, a_mosi, a_csb, a_busy, a_done;
  logic b_ready, b_sclk, b_mosi, b_csb, b_busy, b_done;
  logic [1:0] v_ready, v_sclk, v_mosi, v_csb, v_busy, v_done;

  assign v_ready = {b_ready, a_ready};
  assign v_sclk  = {b_sclk, a_sclk};
  assign v_mosi  = {b_mosi, a_mosi};
  assign v_csb   = {b_csb, a_csb};
  assign v_busy  = {b_busy, a_busy};
  assign v_done  = {b_done, a_done};

  spi_reg_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(a_ready),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]), .cmd_len(cmd_len[0]),
    .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_csb(a_csb), .busy(a_busy), .done(a_done)
  );

  spi_reg_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(b_ready),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]), .cmd_len(cmd_len[1]),
    .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_csb(b_csb), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [23:0] d, input logic [4:0] len);
    exp_t r;
    int   l;
    l      = (len > 5'd24) ? 24 : int'(len);
    r.n    = 4 + l;
    r.addr = a;
    r.data = d & 24'((32'd1 << l) - 32'd1);
    return r;
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  // Receiver modelling the register port: shifts MOSI on SCLK rising edges while csb is low.
  exp_t        expq0[$];
  exp_t        expq1[$];
  logic [27:0] rx_bits [2] = '{28'd0, 28'd0};
  int          rx_n    [2] = '{0, 0};
  int          low_cnt [2] = '{0, 0};
  int          hi_cnt  [2] = '{0, 0};
  int          last_gap[2] = '{0, 0};
  int          frames  [2] = '{0, 0};
  int          done_tot[2] = '{0, 0};
  logic        sclk_prev[2] = '{1'b0, 1'b0};
  logic        csb_prev [2] = '{1'b1, 1'b1};

  task automatic complete(input int k);
    exp_t        e;
    int          sz;
    int          pl;
    logic [31:0] ad;
    logic [31:0] da;
    frames[k]++;
    check("done_at_csb_rise", 32'(v_done[k]), 32'd1);
    sz = (k == 0) ? expq0.size() : expq1.size();
    check("frame_expected", 32'(sz > 0), 32'd1);
    if (sz == 0) return;
    if (k == 0) e = expq0.pop_front();
    else        e = expq1.pop_front();
    pl = (rx_n[k] > 4) ? rx_n[k] - 4 : 0;
    ad = 32'(rx_bits[k] >> pl) & 32'hF;
    da = 32'(rx_bits[k]) & ((32'd1 << pl) - 32'd1);
    check("sclk_edges", rx_n[k], e.n);
    check("rx_addr", ad, 32'(e.addr));
    check("rx_data", da, 32'(e.data));
    check("csb_low_cycles", low_cnt[k], div_of(k) * (2 * e.n + 1));
  endtask

  task automatic mon_step(input int k);
    if (v_done[k] === 1'b1) done_tot[k]++;
    if (v_csb[k] === 1'b0) begin
      if (csb_prev[k]) begin
        last_gap[k] = hi_cnt[k];
        rx_bits[k]  = '0;
        rx_n[k]     = 0;
        low_cnt[k]  = 0;
      end
      low_cnt[k]++;
      if (v_sclk[k] && !sclk_prev[k]) begin
        rx_bits[k] = {rx_bits[k][26:0], v_mosi[k]};
        rx_n[k]++;
      end
    end else begin
      if (!csb_prev[k]) begin
        hi_cnt[k] = 0;
        if (rst_n) complete(k);
      end
      hi_cnt[k]++;
    end
    sclk_prev[k] = v_sclk[k];
    csb_prev[k]  = v_csb[k];
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic start_cmd(input int k, input logic [3:0] a, input logic [23:0] d,
                           input logic [4:0] l, input exp_t e, input bit keep);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid[k] = 1'b1;
    cmd_addr[k]  = a;
    cmd_data[k]  = d;
    cmd_len[k]   = l;
    while (!v_ready[k] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("handshake_ready", 32'(v_ready[k]), 32'd1);
    if (k == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid[k] = 1'b0;
  endtask

  // Counts the cycle index (handshake cycle = 0) at which cmd_ready is next seen high.
  task automatic wait_ready(input int k, output int lat);
    lat = 1;
    @(negedge clk);
    while (!v_ready[k] && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs [8];

  initial begin
    exp_t       e;
    int         lat;
    int         sent0;
    int         t;
    logic [3:0] ra;
    logic [23:0] rd;
    logic [4:0] rl;

    sent0     = 0;
    cmd_valid = '0;
    for (int k = 0; k < 2; k++) begin
      cmd_addr[k] = '0;
      cmd_data[k] = '0;
      cmd_len[k]  = '0;
    end
    vecs[0] = '{4'h3, 24'h0000A5, 5'd8,  12, 24'h0000A5};
    vecs[1] = '{4'hF, 24'h000000, 5'd0,   4, 24'h000000};
    vecs[2] = '{4'h0, 24'hFFFFFF, 5'd31, 28, 24'hFFFFFF};
    vecs[3] = '{4'hA, 24'h123456, 5'd24, 28, 24'h123456};
    vecs[4] = '{4'h5, 24'h000003, 5'd1,   5, 24'h000001};
    vecs[5] = '{4'h1, 24'hFFFF00, 5'd12, 16, 24'h000F00};
    vecs[6] = '{4'hC, 24'h800001, 5'd25, 28, 24'h800001};
    vecs[7] = '{4'h6, 24'hABCDEF, 5'd0,   4, 24'h000000};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csb",   32'(a_csb),   32'd1);
    check("rst_sclk",  32'(a_sclk),  32'd0);
    check("rst_mosi",  32'(a_mosi),  32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(a_ready), 32'd1);
    check("busy_after_reset",  32'(a_busy),  32'd0);

    foreach (vecs[i]) begin
      e = '{vecs[i].n, vecs[i].addr, vecs[i].pay};
      start_cmd(0, vecs[i].addr, vecs[i].data, vecs[i].len, e, 1'b0);
      wait_ready(0, lat);
      check("vec_latency", lat, DIV0 * (2 * vecs[i].n + 1) + GAP + 1);
      sent0++;
    end

    // Back-to-back: valid stays high, second command is taken in the first IDLE cycle.
    start_cmd(0, 4'h2, 24'h00BEEF, 5'd16, model(4'h2, 24'h00BEEF, 5'd16), 1'b1);
    cmd_addr[0] = 4'h9;
    cmd_data[0] = 24'h5A5A5A;
    cmd_len[0]  = 5'd12;
    wait_ready(0, lat);
    check("b2b_first_idle", lat, DIV0 * (2 * 20 + 1) + GAP + 1);
    expq0.push_back(model(4'h9, 24'h5A5A5A, 5'd12));
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    wait_ready(0, lat);
    check("b2b_latency2", lat, DIV0 * (2 * 16 + 1) + GAP + 1);
    // csb stays high through GAP plus the IDLE handshake cycle
    check("b2b_csb_gap", last_gap[0], GAP + 1);
    sent0 += 2;

    // Mid-frame reset on a 28-bit frame after the 5th SCLK rising edge.
    start_cmd(0, 4'h7, 24'hF0F0F0, 5'd24, model(4'h7, 24'hF0F0F0, 5'd24), 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (rx_n[0] < 5 && t < 500);
    check("abort_edge5_reached", 32'(rx_n[0] >= 5), 32'd1);
    check("abort_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_csb",  32'(a_csb),  32'd1);
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    expq0.delete();
    t = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_sclk !== 1'b0 || a_done !== 1'b0) t++;
    end
    check("abort_quiet", t, 0);
    rst_n = 1'b1;
    e = '{vecs[3].n, vecs[3].addr, vecs[3].pay};
    start_cmd(0, vecs[3].addr, vecs[3].data, vecs[3].len, e, 1'b0);
    wait_ready(0, lat);
    check("post_abort_latency", lat, DIV0 * (2 * 28 + 1) + GAP + 1);
    sent0++;

    // CLK_DIV=1 instance, random commands through the receiver scoreboard.
    for (int i = 0; i < 100; i++) begin
      ra = 4'($urandom);
      rd = 24'($urandom);
      rl = 5'($urandom_range(0, 31));
      e  = model(ra, rd, rl);
      start_cmd(1, ra, rd, rl, e, 1'b0);
      wait_ready(1, lat);
      check("rand_latency", lat, DIV1 * (2 * e.n + 1) + GAP + 1);
    end

    repeat (4) @(negedge clk);
    check("frames_a",  frames[0],   sent0);
    check("done_a",    done_tot[0], sent0);
    check("frames_b",  frames[1],   100);
    check("done_b",    done_tot[1], 100);
    check("pending_a", expq0.size(), 0);
    check("pending_b", expq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
